nmos_dyn_demux: RTL and testbench
=================================

# nmos_dyn_demux

Write-side counterpart of the three-source storage mux: one data input is distributed to three dynamic storage nodes selected by one-hot-ish select strobes. Each node models NMOS dynamic behaviour: precharge to 1, conditional pull-down on write, and charge leakage to 0 after a programmable number of cycles without refresh. It sits in the gate-level NMOS cell library and replaces hand-built latch/precharge groups on internal chip buses.

## Interface
- W, 1: data width of D and of each node output.
- DECAY_CYC, 0: cycles a node retains its value after its last refresh; 0 disables decay.
- main_clk  input  1  simulation main clock; all state updates on its rising edge.
- main_rst  input  1  synchronous, active-high reset.
- D  input  W  data to be written.
- SA  input  1  write strobe for node A.
- SB  input  1  write strobe for node B.
- SC  input  1  write strobe for node C.
- PC  input  1  precharge strobe; applies to all three nodes.
- QA  output  W  node A value.
- QB  output  W  node B value.
- QC  output  W  node C value.
- VLD  output  3  per-node retention flag {C,B,A}; 1 = node refreshed within DECAY_CYC cycles.

## Operation
- Each node n in {A,B,C} holds a W-bit register Qn, a VLD bit and an age counter (width clog2(DECAY_CYC+1), minimum 1).
- Per edge, per node, priority highest first:
  - main_rst: Qn = all ones, VLD = 0, age = 0.
  - Sn = 1: Qn = D, VLD = 1, age = 0 (write; pull-down dominates precharge, so PC is ignored for this node).
  - PC = 1: Qn = all ones, VLD = 1, age = 0.
  - DECAY_CYC > 0 and VLD = 1: age increments; when age reaches DECAY_CYC, on that same edge Qn = all zeros, VLD = 0, and age holds at DECAY_CYC (saturates, no wrap).
  - Otherwise hold.
- Several strobes high in one cycle: every selected node takes D (broadcast); unselected nodes take PC if high.
- DECAY_CYC = 0: nodes hold indefinitely; VLD goes to 1 on first refresh and stays 1 until reset.
- Outputs are direct register values; no combinational path from D, strobes or PC to any output.

## Timing
- Reset values: QA = QB = QC = all ones, VLD = 3'b000.
- Write/precharge latency: 1 cycle (value visible after the sampling edge).
- Decay: a node refreshed at edge t with no further refresh shows all zeros and VLD = 0 after edge t + DECAY_CYC; it is unchanged through edge t + DECAY_CYC - 1.
- A refresh on the exact edge where decay would occur wins: node takes the new value, age = 0.
- Reset asserted mid-retention clears age; decay restarts only after the next refresh.
- Strobes are level-sampled; holding a strobe high refreshes every cycle and prevents decay.

## Test plan
- Reset: assert main_rst 2 cycles with SA = PC = 1 -> QA = QB = QC = 1, VLD = 000 after release.
- Demux write, W = 4: D = 4'hA, SB = 1 for one cycle -> next cycle QB = 4'hA, QA = QC = 4'hF, VLD = 010.
- Precharge vs write: PC = 1, SA = 1, D = 0 -> QA = 0, QB = QC = all ones, VLD = 111.
- Broadcast: SA = SB = SC = 1, D = 4'h5 -> all nodes 4'h5, VLD = 111.
- Decay, DECAY_CYC = 3: write SC at edge 0, idle -> QC holds through edge 2, QC = 0 and VLD[2] = 0 after edge 3; stays 0 through edge 10; rewrite at edge 3 instead -> value retained, age reset.
- Reset mid-retention, DECAY_CYC = 3: write SA, assert main_rst at edge 1 -> QA = all ones, VLD[0] = 0, no decay event on later edges until the next write.

Source files
------------

// File: rtl/nmos_dyn_demux.sv
// Write-side demux onto three NMOS-style dynamic storage nodes.
// Each node precharges to ones, is pulled down by a write, and leaks to zeros without refresh.
module nmos_dyn_demux #(
    parameter int unsigned W         = 1,
    parameter int unsigned DECAY_CYC = 0
) (
    input  logic         main_clk,
    input  logic         main_rst,
    input  logic [W-1:0] D,
    input  logic         SA,
    input  logic         SB,
    input  logic         SC,
    input  logic         PC,
    output logic [W-1:0] QA,
    output logic [W-1:0] QB,
    output logic [W-1:0] QC,
    output logic [2:0]   VLD
);

    localparam int unsigned AGE_W = (DECAY_CYC < 1) ? 1 : $clog2(DECAY_CYC + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(DECAY_CYC);
    localparam bit DECAY_EN = (DECAY_CYC != 0);

    logic [2:0] sel;
    assign sel = {SC, SB, SA};

    for (genvar n = 0; n < 3; n++) begin : g_node
        logic [W-1:0]     q_r;
        logic             vld_r;
        logic [AGE_W-1:0] age_r;
        logic [AGE_W-1:0] age_inc;

        assign age_inc = age_r + AGE_W'(1);

        // Write dominates precharge; leakage only acts on an unrefreshed, valid node.
        always_ff @(posedge main_clk) begin
            if (main_rst) begin
                q_r   <= {W{1'b1}};
                vld_r <= 1'b0;
                age_r <= '0;
            end else if (sel[n]) begin
                q_r   <= D;
                vld_r <= 1'b1;
                age_r <= '0;
            end else if (PC) begin
                q_r   <= {W{1'b1}};
                vld_r <= 1'b1;
                age_r <= '0;
            end else if (DECAY_EN && vld_r) begin
                if (age_inc == AGE_MAX) begin
                    q_r   <= '0;
                    vld_r <= 1'b0;
                    age_r <= AGE_MAX;
                end else begin
                    age_r <= age_inc;
                end
            end
        end
    end

    assign QA  = g_node[0].q_r;
    assign QB  = g_node[1].q_r;
    assign QC  = g_node[2].q_r;
    assign VLD = {g_node[2].vld_r, g_node[1].vld_r, g_node[0].vld_r};

endmodule

// File: tb/tb_nmos_dyn_demux.sv
// Bench for nmos_dyn_demux: two instances (DECAY_CYC = 3 and 0) against a refresh-history model.
module tb_nmos_dyn_demux;
    localparam int unsigned W = 4;
    localparam int DEC [2] = '{3, 0};

    logic         main_clk = 1'b0;
    logic         main_rst = 1'b0;
    logic [W-1:0] D  = '0;
    logic         SA = 1'b0, SB = 1'b0, SC = 1'b0, PC = 1'b0;
    logic [W-1:0] qa [2];
    logic [W-1:0] qb [2];
    logic [W-1:0] qc [2];
    logic [2:0]   vld [2];

    int vectors = 0;
    int errors  = 0;

    // Model state: last refresh value, whether refreshed since reset, edges since refresh.
    logic [W-1:0] last_val [2][3];
    bit           refreshed [2][3];
    int           since [2][3];

    nmos_dyn_demux #(.W(W), .DECAY_CYC(3)) dut3 (
        .main_clk(main_clk), .main_rst(main_rst), .D(D),
        .SA(SA), .SB(SB), .SC(SC), .PC(PC),
        .QA(qa[0]), .QB(qb[0]), .QC(qc[0]), .VLD(vld[0])
    );

    nmos_dyn_demux #(.W(W), .DECAY_CYC(0)) dut0 (
        .main_clk(main_clk), .main_rst(main_rst), .D(D),
        .SA(SA), .SB(SB), .SC(SC), .PC(PC),
        .QA(qa[1]), .QB(qb[1]), .QC(qc[1]), .VLD(vld[1])
    );

    always #5 main_clk = ~main_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual running required finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] exp_q(int i, int n);
        if (!refreshed[i][n]) return {W{1'b1}};
        if (DEC[i] > 0 && since[i][n] >= DEC[i]) return '0;
        return last_val[i][n];
    endfunction

    function automatic logic exp_v(int i, int n);
        if (!refreshed[i][n]) return 1'b0;
        return !(DEC[i] > 0 && since[i][n] >= DEC[i]);
    endfunction

    // Apply the inputs present at this edge to the refresh history.
    task automatic model_edge();
        logic [2:0] s;
        s = {SC, SB, SA};
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 3; n++) begin
                if (main_rst) begin
                    refreshed[i][n] = 1'b0;
                    since[i][n]     = 0;
                end else if (s[n] || PC) begin
                    last_val[i][n]  = s[n] ? D : {W{1'b1}};
                    refreshed[i][n] = 1'b1;
                    since[i][n]     = 0;
                end else if (since[i][n] < 1000) begin
                    since[i][n]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [W-1:0] eq [3];
        logic [W-1:0] aq [3];
        logic [2:0]   ev;
        for (int i = 0; i < 2; i++) begin
            aq[0] = qa[i]; aq[1] = qb[i]; aq[2] = qc[i];
            for (int n = 0; n < 3; n++) begin
                eq[n] = exp_q(i, n);
                ev[n] = exp_v(i, n);
            end
            vectors++;
            if (aq[0] !== eq[0] || aq[1] !== eq[1] || aq[2] !== eq[2] || vld[i] !== ev) begin
                errors++;
                $display("FAIL model dec=%0d t=%0t: actual Q=%h/%h/%h VLD=%b, required Q=%h/%h/%h VLD=%b",
                         DEC[i], $time, aq[0], aq[1], aq[2], vld[i], eq[0], eq[1], eq[2], ev);
            end
        end
    endtask

    task automatic step();
        @(posedge main_clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic lit(string name, int act, int req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive(logic r, logic [W-1:0] d, logic a, logic b, logic c, logic p);
        main_rst = r; D = d; SA = a; SB = b; SC = c; PC = p;
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int n = 0; n < 3; n++) begin
                last_val[i][n] = '1; refreshed[i][n] = 1'b0; since[i][n] = 0;
            end
        #1;

        // Reset held two cycles with strobes active.
        drive(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(); step();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("reset_q", int'({qa[0], qb[0], qc[0]}), 'hFFF);
        lit("reset_vld", int'(vld[0]), 0);

        // Single demux write to node B.
        drive(1'b0, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        lit("write_b_q", int'({qa[0], qb[0], qc[0]}), 'hFAF);
        lit("write_b_vld", int'(vld[0]), 'b010);

        // Write to A beats precharge; B and C precharge.
        drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        lit("pc_vs_write_q", int'({qa[0], qb[0], qc[0]}), 'h0FF);
        lit("pc_vs_write_vld", int'(vld[0]), 'b111);

        // Broadcast.
        drive(1'b0, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        lit("broadcast_q", int'({qa[0], qb[0], qc[0]}), 'h555);
        lit("broadcast_vld", int'(vld[0]), 'b111);

        // Decay of node C: write at edge 0, idle afterwards.
        drive(1'b0, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        lit("decay_hold_edge2", int'(qc[0]), 'h9);
        lit("decay_hold_vld", int'(vld[0][2]), 1);
        step();
        lit("decay_edge3_q", int'(qc[0]), 0);
        lit("decay_edge3_vld", int'(vld[0][2]), 0);
        for (int k = 4; k <= 10; k++) step();
        lit("decay_edge10_q", int'(qc[0]), 0);
        lit("nodecay_q", int'(qc[1]), 'h9);
        lit("nodecay_vld", int'(vld[1]), 'b111);

        // Refresh on the decay edge wins.
        drive(1'b0, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        drive(1'b0, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        lit("refresh_on_decay_q", int'(qc[0]), 'hC);
        lit("refresh_on_decay_vld", int'(vld[0][2]), 1);
        step();
        lit("refresh_then_decay_q", int'(qc[0]), 0);

        // Reset during retention; no decay afterwards until the next write.
        drive(1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) step();
        lit("reset_mid_q", int'(qa[0]), 'hF);
        lit("reset_mid_vld", int'(vld[0][0]), 0);

        // Randomized traffic with sparse strobes so leakage is exercised.
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 49) == 0), W'($urandom),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
